// File: rtl/histo_pkg.sv
// Shared definitions for the histogram frame packer: FSM state encoding,
// frame tag bytes, default geometry and small word-building helpers.
package histo_pkg;

  localparam int DEFAULT_NUM_BINS = 1024;
  localparam int DEFAULT_ADDR_W   = 10;

  localparam logic [7:0] HEADER_TAG  = 8'hAA;
  localparam logic [7:0] TRAILER_TAG = 8'h55;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  function automatic logic [31:0] header_word(input logic [7:0]  frame_id,
                                              input logic [15:0] num_bins);
    return {HEADER_TAG, frame_id, num_bins};
  endfunction

  function automatic logic [31:0] trailer_word(input logic [7:0] frame_id);
    return {TRAILER_TAG, frame_id, 16'h0000};
  endfunction

endpackage

// File: rtl/histo_bin_prefetch.sv
// Bin RAM reader: walks the bin addresses in ascending order, one read per
// request, and captures the returned word (one-cycle RAM latency) into a
// prefetch register that the frame packer loads into its output word.
module histo_bin_prefetch
  import histo_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_first,
  input  logic              fetch_next,
  output logic [ADDR_W-1:0] bin_addr,
  output logic              bin_rd_en,
  input  logic [31:0]       bin_rd_data,
  output logic [31:0]       prefetch_data
);

  logic rd_pending;

  // Issue one read per request and capture the RAM word the cycle after the strobe.
  // NOTE: every register here, including the prefetch data word, is cleared by the
  // asynchronous reset so a reset mid-frame leaves no stale bin value behind; all
  // state updates use non-blocking assignments so reads of bin_rd_en / bin_addr
  // below see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_addr      <= '0;
      bin_rd_en     <= 1'b0;
      rd_pending    <= 1'b0;
      prefetch_data <= '0;
    end else begin
      bin_rd_en <= fetch_first | fetch_next;
      if (fetch_first) begin
        bin_addr <= '0;
      end else if (fetch_next) begin
        bin_addr <= bin_addr + ADDR_W'(1);
      end
      rd_pending <= bin_rd_en;
      if (rd_pending) begin
        prefetch_data <= bin_rd_data;
      end
    end
  end

endmodule

// File: rtl/histo_frame_packer.sv
// Histogram frame packer: on frame_start, streams HEADER, every bin word,
// optional CHECKSUM and TRAILER to a byte serializer, one word per word_done.
// Optional feature macro: HISTO_CHECKSUM_EN adds a running 32-bit sum of the
// bins, emitted as an extra word between the last bin and the trailer.
module histo_frame_packer
  import histo_pkg::*;
#(
  parameter int NUM_BINS = DEFAULT_NUM_BINS,
  parameter int ADDR_W   = DEFAULT_ADDR_W
) (
  input  logic              fast_clk_in,
  input  logic              reset_n,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] bin_addr,
  output logic              bin_rd_en,
  input  logic [31:0]       bin_rd_data,
  input  logic              word_done,
  output logic [31:0]       data_out,
  output logic              ser_reset,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        drop_cnt
);

  // Word index counter holds 0..NUM_WORDS; two spare bits cover the extra words.
  localparam int CNT_W = ADDR_W + 2;
`ifdef HISTO_CHECKSUM_EN
  localparam int NUM_WORDS = NUM_BINS + 3;
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(NUM_BINS + 1);
`else
  localparam int NUM_WORDS = NUM_BINS + 2;
`endif
  localparam logic [CNT_W-1:0] LAST_BIN_IDX = CNT_W'(NUM_BINS);
  localparam logic [CNT_W-1:0] TRAILER_IDX  = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0] END_IDX      = CNT_W'(NUM_WORDS);

  state_t           state, state_next;
  logic [CNT_W-1:0] word_idx, word_idx_next;
  logic [7:0]       frame_id;
  logic [31:0]      prefetch_data;
  logic [31:0]      stream_word;
  logic             load_hdr, step, close, fetch_first, fetch_next;
`ifdef HISTO_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  assign word_idx_next = word_idx + CNT_W'(1);
  assign fetch_next    = step && (word_idx_next < LAST_BIN_IDX);
  assign ser_reset     = (state == ST_IDLE) || (state == ST_LOAD);
  assign busy          = (state != ST_IDLE);

  histo_bin_prefetch #(
    .ADDR_W(ADDR_W)
  ) u_prefetch (
    .clk          (fast_clk_in),
    .rst_n        (reset_n),
    .fetch_first  (fetch_first),
    .fetch_next   (fetch_next),
    .bin_addr     (bin_addr),
    .bin_rd_en    (bin_rd_en),
    .bin_rd_data  (bin_rd_data),
    .prefetch_data(prefetch_data)
  );

  // FSM state register.
  always_ff @(posedge fast_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  // NOTE: every signal written in this block gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    load_hdr    = 1'b0;
    fetch_first = 1'b0;
    step        = 1'b0;
    close       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        load_hdr    = 1'b1;
        fetch_first = 1'b1;
        state_next  = ST_STREAM;
      end
      ST_STREAM: begin
        if (word_done) begin
          step = 1'b1;
          if (word_idx_next == END_IDX) state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (word_done) begin
          close      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Word mux: which word the next word_done puts on data_out (0 once the frame is out).
  always_comb begin
    stream_word = '0;
    if (word_idx_next <= LAST_BIN_IDX) begin
      stream_word = prefetch_data;
    end
`ifdef HISTO_CHECKSUM_EN
    else if (word_idx_next == CSUM_IDX) begin
      stream_word = checksum;
    end
`endif
    else if (word_idx_next == TRAILER_IDX) begin
      stream_word = trailer_word(frame_id);
    end
  end

  // Output word, word index, frame id, completion pulse and drop counter.
  always_ff @(posedge fast_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      word_idx   <= '0;
      frame_id   <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= close;
      if (load_hdr) begin
        data_out <= header_word(frame_id, 16'(NUM_BINS));
        word_idx <= '0;
      end else if (step) begin
        data_out <= stream_word;
        word_idx <= word_idx_next;
      end
      if (close) begin
        frame_id <= frame_id + 8'd1;
      end
      if (frame_start && (state != ST_IDLE) && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef HISTO_CHECKSUM_EN
  // Running sum of bin words, cleared at the header and added as each bin goes out.
  always_ff @(posedge fast_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= '0;
    end else if (load_hdr) begin
      checksum <= '0;
    end else if (step && (word_idx_next <= LAST_BIN_IDX)) begin
      checksum <= checksum + prefetch_data;
    end
  end
`endif

endmodule

// File: tb/tb_histo_frame_packer.sv
// Scoreboard bench for histo_frame_packer (NUM_BINS=4). The driver builds each
// expected frame from the bin contents and pushes it into a queue; a monitor
// pops one entry per output event (header load, each word_done while streaming)
// and also watches output stability, stray frame_done and the read address order.
module tb_histo_frame_packer;

  localparam int NUM_BINS = 4;
  localparam int ADDR_W   = 2;
`ifdef HISTO_CHECKSUM_EN
  localparam int W = NUM_BINS + 3;
`else
  localparam int W = NUM_BINS + 2;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              word_done = 1'b0;
  logic [ADDR_W-1:0] bin_addr;
  logic              bin_rd_en;
  logic [31:0]       bin_rd_data;
  logic [31:0]       data_out;
  logic              ser_reset, busy, frame_done;
  logic [7:0]        drop_cnt;

  typedef struct {
    logic [31:0] data;
    logic        fd;
    logic        sr;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  id_m = 8'd0;
  int          drop_m = 0;
  logic [31:0] mem [NUM_BINS];

  histo_frame_packer #(
    .NUM_BINS(NUM_BINS),
    .ADDR_W  (ADDR_W)
  ) dut (
    .fast_clk_in(clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .bin_addr   (bin_addr),
    .bin_rd_en  (bin_rd_en),
    .bin_rd_data(bin_rd_data),
    .word_done  (word_done),
    .data_out   (data_out),
    .ser_reset  (ser_reset),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Histogram RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (bin_rd_en) bin_rd_data <= mem[bin_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: header, bins, optional sum, trailer, then the two closing events.
  task automatic push_frame();
    logic [31:0] sum = 32'd0;
    exp_q.push_back('{data: {8'hAA, id_m, 16'(NUM_BINS)}, fd: 1'b0, sr: 1'b0});
    for (int i = 0; i < NUM_BINS; i++) begin
      exp_q.push_back('{data: mem[i], fd: 1'b0, sr: 1'b0});
      sum = sum + mem[i];
    end
`ifdef HISTO_CHECKSUM_EN
    exp_q.push_back('{data: sum, fd: 1'b0, sr: 1'b0});
`endif
    exp_q.push_back('{data: {8'h55, id_m, 16'h0000}, fd: 1'b0, sr: 1'b0});
    exp_q.push_back('{data: 32'd0, fd: 1'b0, sr: 1'b0});
    exp_q.push_back('{data: 32'd0, fd: 1'b1, sr: 1'b1});
    id_m = id_m + 8'd1;
  endtask

  task automatic bump_drop();
    if (drop_m < 255) drop_m++;
  endtask

  // Drive inputs for one clock cycle, starting and ending on a falling edge.
  task automatic cycle(input logic fs, input logic wd);
    frame_start = fs;
    word_done   = wd;
    @(negedge clk);
    frame_start = 1'b0;
    word_done   = 1'b0;
  endtask

  task automatic run_frame(input bit fixed_mem, input int gmin, input int gmax,
                           input int drops, input bit clash, input bit poke);
    int left = drops;
    for (int i = 0; i < NUM_BINS; i++) begin
      mem[i] = fixed_mem ? 32'h11111111 * (i + 1) : $urandom;
    end
    push_frame();
    if (poke) begin
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0);
    if (poke) cycle(1'b0, 1'b1);
    for (int p = 1; p <= W + 1; p++) begin
      int gap = $urandom_range(gmax, gmin);
      for (int c = 1; c < gap; c++) begin
        if (left > 0) begin
          cycle(1'b1, 1'b0);
          left--;
          bump_drop();
        end else begin
          cycle(1'b0, 1'b0);
        end
      end
      if (p == W + 1 && clash) begin
        cycle(1'b1, 1'b1);
        bump_drop();
      end else begin
        cycle(1'b0, 1'b1);
      end
    end
    repeat (3) cycle(1'b0, 1'b0);
    check("drop_cnt", drop_cnt, drop_m);
    check("busy_after_frame", busy, 1'b0);
    check("ser_reset_after_frame", ser_reset, 1'b1);
  endtask

  // Monitor: inputs and outputs captured just before each rising edge, results #1 after it.
  initial begin
    logic        wd_e, sr_e, rd_e, rst_e;
    logic [ADDR_W-1:0] addr_e;
    logic [31:0] last = 32'd0;
    int          rd_count = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #3;
      wd_e   = word_done;
      sr_e   = ser_reset;
      rd_e   = bin_rd_en;
      addr_e = bin_addr;
      rst_e  = reset_n;
      @(posedge clk);
      #1;
      if (!rst_e || !reset_n) begin
        last     = 32'd0;
        rd_count = 0;
        continue;
      end
      if (rd_e) begin
        check("read_addr_order", 32'(addr_e), rd_count);
        check("read_once", rd_count < NUM_BINS, 1'b1);
        rd_count++;
      end
      if ((sr_e && !ser_reset) || (wd_e && !sr_e)) begin
        check("queue_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data_out", data_out, e.data);
          check("frame_done", frame_done, e.fd);
          check("ser_reset", ser_reset, e.sr);
          check("busy", busy, !e.fd);
          if (e.fd) begin
            check("reads_per_frame", rd_count, NUM_BINS);
            rd_count = 0;
          end
        end
      end else begin
        check("data_out_stable", data_out, last);
        check("no_stray_frame_done", frame_done, 1'b0);
      end
      last = data_out;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", data_out, 32'd0);
    check("rst_ser_reset", ser_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_en", bin_rd_en, 1'b0);
    check("rst_addr", 32'(bin_addr), 32'd0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Reference frame with fixed bins, then two random ones (ids 0,1,2).
    run_frame(1'b1, 40, 40, 0, 1'b0, 1'b0);
    run_frame(1'b0, 32, 45, 0, 1'b0, 1'b1);
    run_frame(1'b0, 32, 45, 0, 1'b0, 1'b0);
    // Three rejected requests mid-frame, then enough to saturate the counter.
    run_frame(1'b0, 40, 40, 3, 1'b0, 1'b0);
    run_frame(1'b0, 45, 50, 300, 1'b1, 1'b0);

    // Reset after the second bin has gone out.
    for (int i = 0; i < NUM_BINS; i++) mem[i] = $urandom;
    push_frame();
    cycle(1'b1, 1'b0);
    for (int p = 1; p <= 2; p++) begin
      repeat (39) cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
    end
    repeat (10) cycle(1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_data_out", data_out, 32'd0);
    check("midrst_ser_reset", ser_reset, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd_en", bin_rd_en, 1'b0);
    check("midrst_addr", 32'(bin_addr), 32'd0);
    check("midrst_frame_done", frame_done, 1'b0);
    check("midrst_drop_cnt", drop_cnt, 8'd0);
    check("midrst_words_left", exp_q.size(), W - 1);
    exp_q.delete();
    id_m   = 8'd0;
    drop_m = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) cycle(1'b0, 1'b0);
    check("post_rst_no_done", frame_done, 1'b0);

    // Fresh frame with id 0; its closing word_done collides with a new request.
    run_frame(1'b0, 32, 40, 0, 1'b1, 1'b0);
    // 256 more frames carry the id through 255 and back to 0.
    for (int f = 0; f < 256; f++) begin
      run_frame(1'b0, 32, 34, 0, 1'b0, 1'b0);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
